fir_feeder: RTL and testbench

Host-side stream source for the W4823 FIR datapath, running on the slow clock `clk1`. It accepts a unified FP16 word stream, writes 64 coefficients into the FIR coefficient memory, then issues samples one at a time. Each sample is paced by the FIR `valid` return.

Coefficients are converted from FP16 to the FP16i coefficient format: explicit hidden bit, denormals unpacked. The block drives the `din`/`valid_in`/`cin`/`caddr`/`cload` ports and consumes the FIR `valid` output.

---
 rtl/fir_feeder_pkg.sv | 34 +++
 rtl/fir_feeder_fp16_to_fp16i.sv | 18 +
 rtl/fir_feeder.sv | 147 ++++++++++++++
 tb/tb_fir_feeder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_feeder_pkg.sv
// Shared types, FP16 field widths and the FP16 -> FP16i coefficient conversion.
package fir_feeder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int unsigned EXP_W   = 5;
  localparam int unsigned MAN_W   = 10;
  localparam int unsigned FP16_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned FP16I_W = FP16_W + 1;

  // Explicit hidden bit; denormals take exponent 1 with hidden bit 0 unless flushed.
  function automatic logic [FP16I_W-1:0] fp16_to_fp16i_f(input logic [FP16_W-1:0] x,
                                                          input logic           flush);
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [FP16I_W-1:0] r;
    s = x[FP16_W-1];
    e = x[FP16_W-2 -: EXP_W];
    m = x[MAN_W-1:0];
    if (e != '0)
      r = {s, e, 1'b1, m};
    else if ((m != '0) && !flush)
      r = {s, EXP_W'(1), 1'b0, m};
    else
      r = {s, {(FP16I_W-1){1'b0}}};
    return r;
  endfunction

endpackage

// File: rtl/fir_feeder_fp16_to_fp16i.sv
// Combinational FP16 -> FP16i coefficient converter.
// FIR_FEEDER_DENORM_FLUSH_EN: when defined, denormal coefficients flush to signed zero.
module fp16_to_fp16i
  import fir_feeder_pkg::*;
(
  input  logic [FP16_W-1:0]  i_fp16,
  output logic [FP16I_W-1:0] o_fp16i
);

`ifdef FIR_FEEDER_DENORM_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  assign o_fp16i = fp16_to_fp16i_f(i_fp16, FLUSH);

endmodule

// File: rtl/fir_feeder.sv
// Host stream source for the FIR: loads NTAPS converted coefficients, then issues
// samples one at a time, each paced by the FIR valid return or a timeout.
module fir_feeder
  import fir_feeder_pkg::*;
#(
  parameter int unsigned CADDR_W = 6,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_coef,
  input  logic [FP16_W-1:0]   s_data,
  output logic [FP16I_W-1:0]  cin,
  output logic [CADDR_W-1:0]  caddr,
  output logic                cload,
  output logic [FP16_W-1:0]   din,
  output logic                valid_in,
  input  logic                fir_valid,
  output logic                coef_loaded,
  output logic                err_timeout,
  output logic [15:0]         n_samples
);

  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CADDR_W-1:0] LAST_ADDR = '1;

  state_t              r_state,   w_state_nxt;
  logic [CADDR_W-1:0]  r_addr,    w_addr_nxt;
  logic [TO_W-1:0]     r_to_cnt,  w_to_nxt;
  logic [FP16I_W-1:0]  r_cin,     w_cin_nxt;
  logic [CADDR_W-1:0]  r_caddr,   w_caddr_nxt;
  logic                r_cload,   w_cload_nxt;
  logic [FP16_W-1:0]   r_din,     w_din_nxt;
  logic                r_vin,     w_vin_nxt;
  logic                r_loaded,  w_loaded_nxt;
  logic                r_err,     w_err_nxt;
  logic [15:0]         r_nsmp,    w_nsmp_nxt;
  logic                w_ready;
  logic [FP16I_W-1:0]  w_cin_conv;

  fp16_to_fp16i u_conv (
    .i_fp16  (s_data),
    .o_fp16i (w_cin_conv)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state  <= ST_LOAD;
      r_addr   <= '0;
      r_to_cnt <= '0;
      r_cin    <= '0;
      r_caddr  <= '0;
      r_cload  <= 1'b0;
      r_din    <= '0;
      r_vin    <= 1'b0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      r_nsmp   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_to_cnt <= w_to_nxt;
      r_cin    <= w_cin_nxt;
      r_caddr  <= w_caddr_nxt;
      r_cload  <= w_cload_nxt;
      r_din    <= w_din_nxt;
      r_vin    <= w_vin_nxt;
      r_loaded <= w_loaded_nxt;
      r_err    <= w_err_nxt;
      r_nsmp   <= w_nsmp_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_to_nxt     = r_to_cnt;
    w_cin_nxt    = r_cin;
    w_caddr_nxt  = r_caddr;
    w_cload_nxt  = 1'b0;
    w_din_nxt    = r_din;
    w_vin_nxt    = 1'b0;
    w_loaded_nxt = r_loaded;
    w_err_nxt    = r_err;
    w_nsmp_nxt   = r_nsmp;
    w_ready      = 1'b0;

    case (r_state)
      ST_LOAD: begin
        w_ready = s_coef;
        if (s_valid && s_coef) begin
          w_cin_nxt   = w_cin_conv;
          w_caddr_nxt = r_addr;
          w_cload_nxt = 1'b1;
          w_addr_nxt  = r_addr + CADDR_W'(1);
          if (r_addr == LAST_ADDR) begin
            w_loaded_nxt = 1'b1;
            w_state_nxt  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_ready = 1'b1;
        if (s_valid && s_coef) begin
          // Coefficient in RUN restarts a full load at address 0.
          w_cin_nxt    = w_cin_conv;
          w_caddr_nxt  = '0;
          w_cload_nxt  = 1'b1;
          w_addr_nxt   = CADDR_W'(1);
          w_loaded_nxt = 1'b0;
          w_state_nxt  = ST_LOAD;
        end else if (s_valid) begin
          w_din_nxt   = s_data;
          w_vin_nxt   = 1'b1;
          w_nsmp_nxt  = r_nsmp + 16'd1;
          w_to_nxt    = '0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response coinciding with expiry wins over the timeout.
        if (fir_valid) begin
          w_state_nxt = ST_RUN;
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign s_ready     = w_ready & ~rst;
  assign cin         = r_cin;
  assign caddr       = r_caddr;
  assign cload       = r_cload;
  assign din         = r_din;
  assign valid_in    = r_vin;
  assign coef_loaded = r_loaded;
  assign err_timeout = r_err;
  assign n_samples   = r_nsmp;

endmodule

// File: tb/tb_fir_feeder.sv
// Scoreboard bench for fir_feeder (TIMEOUT=8); honours FIR_FEEDER_DENORM_FLUSH_EN.
module tb_fir_feeder;

  localparam int unsigned CADDR_W = 6;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned NTAPS   = 64;

  logic         clk1 = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic         s_coef;
  logic [15:0]  s_data;
  logic [16:0]  cin;
  logic [5:0]   caddr;
  logic         cload;
  logic [15:0]  din;
  logic         valid_in;
  logic         fir_valid;
  logic         coef_loaded;
  logic         err_timeout;
  logic [15:0]  n_samples;

  always #5 clk1 = ~clk1;

  fir_feeder #(.CADDR_W(CADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_coef      (s_coef),
    .s_data      (s_data),
    .cin         (cin),
    .caddr       (caddr),
    .cload       (cload),
    .din         (din),
    .valid_in    (valid_in),
    .fir_valid   (fir_valid),
    .coef_loaded (coef_loaded),
    .err_timeout (err_timeout),
    .n_samples   (n_samples)
  );

  typedef struct packed { logic [5:0] addr; logic [16:0] cin; } cexp_t;
  typedef struct packed { logic [15:0] din; logic [15:0] n; } sexp_t;

  cexp_t cq[$];
  sexp_t sq[$];
  cexp_t ce;
  sexp_t se;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_addr   = 0;
  bit          m_loaded = 0;
  logic [15:0] m_n      = '0;
  int          vin_pulses = 0;
  logic        prev_vin = 1'b0;

  function automatic logic [16:0] ref_conv(input logic [15:0] x);
    logic [4:0] e;
    e = x[14:10];
    if (e != 5'd0) return {x[15], e, 1'b1, x[9:0]};
`ifdef FIR_FEEDER_DENORM_FLUSH_EN
    return {x[15], 16'h0000};
`else
    if (x[9:0] == 10'd0) return {x[15], 16'h0000};
    return {x[15], 5'd1, 1'b0, x[9:0]};
`endif
  endfunction

  // Scoreboard: every write strobe must match the oldest expected transaction.
  always @(negedge clk1) begin
    if (!rst) begin
      if (cload) begin
        n_checks++;
        if (cq.size() == 0) begin
          n_fail++;
          $display("FAIL cload_unexpected caddr=%h cin=%h", caddr, cin);
        end else begin
          ce = cq.pop_front();
          if (caddr !== ce.addr || cin !== ce.cin) begin
            n_fail++;
            $display("FAIL coef_write got caddr=%h cin=%h exp caddr=%h cin=%h", caddr, cin, ce.addr, ce.cin);
          end
        end
      end
      if (valid_in) begin
        vin_pulses++;
        n_checks++;
        if (sq.size() == 0) begin
          n_fail++;
          $display("FAIL valid_in_unexpected din=%h", din);
        end else begin
          se = sq.pop_front();
          if (din !== se.din || n_samples !== se.n || prev_vin !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_issue got din=%h n=%0d prev_vin=%b exp din=%h n=%0d prev_vin=0",
                     din, n_samples, prev_vin, se.din, se.n);
          end
        end
      end
      prev_vin = valid_in;
    end
  end

  task automatic send_coef(input logic [15:0] d, input logic [16:0] exp_cin);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_coef = 1'b1; s_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (s_ready) begin
        if (m_loaded) begin m_addr = 0; m_loaded = 0; end
        cq.push_back('{addr: 6'(m_addr), cin: exp_cin});
        m_addr = (m_addr + 1) % NTAPS;
        if (m_addr == 0) m_loaded = 1;
        @(posedge clk1); #1;
        ok = 1;
        break;
      end
      @(posedge clk1); #1;
    end
    s_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL coef_accept_timeout got s_ready=0 exp s_ready=1 data=%h", d);
    end
  endtask

  task automatic send_sample(input logic [15:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_coef = 1'b0; s_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (s_ready) begin
        m_n = m_n + 16'd1;
        sq.push_back('{din: d, n: m_n});
        @(posedge clk1); #1;
        ok = 1;
        break;
      end
      @(posedge clk1); #1;
    end
    s_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sample_accept_timeout got s_ready=0 exp s_ready=1 data=%h", d);
    end
  endtask

  task automatic pulse_fir_valid();
    fir_valid = 1'b1;
    @(posedge clk1); #1;
    fir_valid = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; fir_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
    m_addr = 0; m_loaded = 0; m_n = '0;
    cq.delete(); sq.delete();
    prev_vin = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 1'b1; s_coef = 1'b1; s_data = 16'h3C00; fir_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #3;
    n_checks++;
    if ({cin, caddr, din, cload, valid_in, coef_loaded, err_timeout, n_samples} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got cin=%h caddr=%h din=%h cload=%b vin=%b loaded=%b err=%b n=%0d exp all 0",
               cin, caddr, din, cload, valid_in, coef_loaded, err_timeout, n_samples);
    end
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got s_ready=%b exp 0", s_ready);
    end
    s_valid = 1'b0;
    @(posedge clk1); #1 rst = 1'b0;
  endtask

  task automatic test_conversion();
    logic [15:0] w [6];
    logic [16:0] x [6];
    logic [15:0] d;
    longint t0;
    w[0] = 16'h3C00; x[0] = 17'h07C00;
    w[1] = 16'hBC00; x[1] = 17'h17C00;
`ifdef FIR_FEEDER_DENORM_FLUSH_EN
    w[2] = 16'h0001; x[2] = 17'h00000;
    w[5] = 16'h8201; x[5] = 17'h10000;
`else
    w[2] = 16'h0001; x[2] = 17'h00801;
    w[5] = 16'h8201; x[5] = 17'h10A01;
`endif
    w[3] = 16'h0000; x[3] = 17'h00000;
    w[4] = 16'h7C00; x[4] = 17'h0FC00;
    t0 = $time;
    for (int i = 0; i < 6; i++) send_coef(w[i], x[i]);
    for (int i = 6; i < 63; i++) begin
      d = 16'($urandom);
      if (i % 4 == 0) d[14:10] = 5'd0;
      send_coef(d, ref_conv(d));
    end
    n_checks++;
    if ($time - t0 != 63 * 10) begin
      n_fail++;
      $display("FAIL coef_throughput got %0d exp %0d", $time - t0, 63 * 10);
    end
    n_checks++;
    if (coef_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL loaded_early got coef_loaded=%b exp 0", coef_loaded);
    end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    s_valid = 1'b1; s_coef = 1'b0; s_data = 16'h1234;
    repeat (5) begin
      @(negedge clk1);
      if (s_ready !== 1'b0 || valid_in !== 1'b0) bad++;
    end
    s_valid = 1'b0;
    @(posedge clk1); #1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_before_load got %0d ready cycles exp 0", bad);
    end
    send_coef(16'h4000, 17'h08400);
    n_checks++;
    if (coef_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL loaded_after_64 got coef_loaded=%b exp 1", coef_loaded);
    end
    send_sample(16'h1234);
    n_checks++;
    if (valid_in !== 1'b1 || din !== 16'h1234 || n_samples !== 16'd1) begin
      n_fail++;
      $display("FAIL first_sample got vin=%b din=%h n=%0d exp vin=1 din=1234 n=1", valid_in, din, n_samples);
    end
    @(posedge clk1); #1;
    pulse_fir_valid();
  endtask

  task automatic test_handshake();
    int p0;
    p0 = vin_pulses;
    for (int k = 0; k < 3; k++) begin
      send_sample(16'($urandom));
      @(negedge clk1);
      n_checks++;
      if (s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_ready got s_ready=%b exp 0", s_ready);
      end
      repeat (4) @(posedge clk1);
      #1 pulse_fir_valid();
    end
    @(negedge clk1);
    n_checks++;
    if (vin_pulses - p0 != 3 || n_samples !== m_n || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake got pulses=%0d n=%0d err=%b exp pulses=3 n=%0d err=0",
               vin_pulses - p0, n_samples, err_timeout, m_n);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_back_to_back();
    longint t0;
    fir_valid = 1'b1;
    send_sample(16'hA001);
    t0 = $time;
    for (int k = 0; k < 3; k++) send_sample(16'(16'hA002 + k));
    n_checks++;
    if ($time - t0 != 3 * 20) begin
      n_fail++;
      $display("FAIL min_gap got %0d exp %0d", $time - t0, 3 * 20);
    end
    @(posedge clk1); #1;
    fir_valid = 1'b0;
  endtask

  task automatic test_timeout();
    logic [15:0] n0;
    send_sample(16'h5555);
    n0 = m_n;
    repeat (7) @(posedge clk1);
    #1;
    n_checks++;
    if (err_timeout !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early got err=%b s_ready=%b exp err=0 s_ready=0", err_timeout, s_ready);
    end
    @(posedge clk1); #1;
    n_checks++;
    if (err_timeout !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_expiry got err=%b s_ready=%b exp err=1 s_ready=1", err_timeout, s_ready);
    end
    pulse_fir_valid();
    @(posedge clk1); #1;
    n_checks++;
    if (s_ready !== 1'b1 || err_timeout !== 1'b1 || n_samples !== n0) begin
      n_fail++;
      $display("FAIL fir_valid_in_run got s_ready=%b err=%b n=%0d exp s_ready=1 err=1 n=%0d",
               s_ready, err_timeout, n_samples, n0);
    end
  endtask

  task automatic test_reload();
    logic [15:0] d;
    send_coef(16'h3800, 17'h07400);
    n_checks++;
    if (caddr !== 6'd0 || cload !== 1'b1 || coef_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_start got caddr=%h cload=%b loaded=%b exp caddr=0 cload=1 loaded=0",
               caddr, cload, coef_loaded);
    end
    s_valid = 1'b1; s_coef = 1'b0; s_data = 16'h7777;
    @(negedge clk1);
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_stall got s_ready=%b exp 0", s_ready);
    end
    s_valid = 1'b0;
    @(posedge clk1); #1;
    for (int i = 1; i < 64; i++) begin
      d = 16'($urandom);
      send_coef(d, ref_conv(d));
    end
    n_checks++;
    if (coef_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_done got coef_loaded=%b exp 1", coef_loaded);
    end
    send_sample(16'h7777);
    @(posedge clk1); #1;
    pulse_fir_valid();
  endtask

  task automatic test_reset_midload();
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      send_coef(d, ref_conv(d));
    end
    @(negedge clk1);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({cin, caddr, din, cload, valid_in, coef_loaded, err_timeout, n_samples} !== '0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset got cin=%h caddr=%h cload=%b loaded=%b err=%b n=%0d rdy=%b exp all 0",
               cin, caddr, cload, coef_loaded, err_timeout, n_samples, s_ready);
    end
    do_reset();
    send_coef(16'hC000, 17'h18400);
    n_checks++;
    if (caddr !== 6'd0 || coef_loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_addr got caddr=%h loaded=%b exp caddr=0 loaded=0", caddr, coef_loaded);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_coef = 1'b0; s_data = '0; fir_valid = 1'b0;
    test_reset();
    test_conversion();
    test_stall();
    test_handshake();
    test_back_to_back();
    test_timeout();
    test_reload();
    test_reset_midload();
    @(negedge clk1);
    @(negedge clk1);
    n_checks++;
    if (cq.size() != 0 || sq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got coef=%0d samples=%0d pending exp 0", cq.size(), sq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
